// File: rtl/cmp_minmax_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmp_minmax_tracker: drives an external 8-bit comparator to track frame     |
// | max/min and sample count.                                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cmp_minmax_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [7:0]       iData,
  input  logic             iValid,
  input  logic             iLast,
  output logic             oReady,
  output logic [7:0]       oCmp_a,
  output logic [7:0]       oCmp_b,
  input  logic [2:0]       iCmp,
  output logic [7:0]       oMax,
  output logic [7:0]       oMin,
  output logic [CNT_W-1:0] oCount,
  output logic             oDone,
  output logic             oErr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMP_MAX = 2'd1,
    S_CMP_MIN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic             w_ready;
  logic             w_done;
  logic             w_accept;
  logic             w_cmp_onehot;
  logic [7:0]       r_cand;
  logic             r_last;
  logic             r_first;
  logic [7:0]       r_max;
  logic [7:0]       r_min;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_cmp_a;
  logic [7:0]       r_cmp_b;
  logic             r_err;

  assign w_accept     = iValid && w_ready;
  assign w_cmp_onehot = (iCmp == 3'b001) || (iCmp == 3'b010) || (iCmp == 3'b100);

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (iValid) begin
          // The first sample of a frame seeds max/min without a comparison.
          if (r_first) w_next = iLast ? S_DONE : S_IDLE;
          else         w_next = S_CMP_MAX;
        end
      end
      S_CMP_MAX: w_next = S_CMP_MIN;
      S_CMP_MIN: w_next = r_last ? S_DONE : S_IDLE;
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
      r_cand  <= 8'h00;
      r_last  <= 1'b0;
      r_first <= 1'b1;
      r_max   <= 8'h00;
      r_min   <= 8'hFF;
      r_count <= '0;
      r_cmp_a <= 8'h00;
      r_cmp_b <= 8'h00;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cand <= iData;
            r_last <= iLast;
            if (r_first) begin
              r_max   <= iData;
              r_min   <= iData;
              r_first <= 1'b0;
              r_count <= CNT_W'(1);
            end else begin
              // Operands are loaded a cycle early so iCmp settles before use.
              r_cmp_a <= iData;
              r_cmp_b <= r_max;
              if (r_count != C_CNT_MAX) r_count <= r_count + CNT_W'(1);
            end
          end
        end
        S_CMP_MAX: begin
          if (iCmp[2])       r_max   <= r_cand;
          if (!w_cmp_onehot) r_err   <= 1'b1;
          r_cmp_a <= r_cand;
          r_cmp_b <= r_min;
        end
        S_CMP_MIN: begin
          if (iCmp[0])       r_min <= r_cand;
          if (!w_cmp_onehot) r_err <= 1'b1;
        end
        S_DONE: r_first <= 1'b1;
        default: ;
      endcase
    end
  end

  assign oReady = w_ready;
  assign oDone  = w_done;
  assign oCmp_a = r_cmp_a;
  assign oCmp_b = r_cmp_b;
  assign oMax   = r_max;
  assign oMin   = r_min;
  assign oCount = r_count;
  assign oErr   = r_err;

endmodule
`default_nettype wire
